// File: rtl/nasti_stream_rr_arbiter.sv
// N:1 packet-level round-robin merge for nasti_stream sources onto one registered output.
// A grant is held from the first beat of a packet until its t_last beat is accepted.
module nasti_stream_rr_arbiter #(
   parameter int unsigned N_PORT     = 4,
   parameter int unsigned ID_WIDTH   = 3,
   parameter int unsigned DEST_WIDTH = 1,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TAG_SRC    = 1
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [N_PORT-1:0]              s_t_valid,
   output logic [N_PORT-1:0]              s_t_ready,
   input  logic [N_PORT*DATA_WIDTH-1:0]   s_t_data,
   input  logic [N_PORT*DATA_WIDTH/8-1:0] s_t_strb,
   input  logic [N_PORT*DATA_WIDTH/8-1:0] s_t_keep,
   input  logic [N_PORT-1:0]              s_t_last,
   input  logic [N_PORT*ID_WIDTH-1:0]     s_t_id,
   input  logic [N_PORT*DEST_WIDTH-1:0]   s_t_dest,
   input  logic [N_PORT*USER_WIDTH-1:0]   s_t_user,
   output logic                           m_t_valid,
   input  logic                           m_t_ready,
   output logic [DATA_WIDTH-1:0]          m_t_data,
   output logic [DATA_WIDTH/8-1:0]        m_t_strb,
   output logic [DATA_WIDTH/8-1:0]        m_t_keep,
   output logic                           m_t_last,
   output logic [ID_WIDTH-1:0]            m_t_id,
   output logic [DEST_WIDTH-1:0]          m_t_dest,
   output logic [USER_WIDTH-1:0]          m_t_user
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_WIDTH  = (N_PORT > 1) ? $clog2(N_PORT) : 1;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e                 state_q, state_d;
   logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [PTR_WIDTH-1:0]   gnt_q, gnt_d;
   logic [PTR_WIDTH-1:0]   sel, cur, cur_next;
   logic                   found, cur_valid, can_load, accept;

   logic                   valid_q;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [STRB_WIDTH-1:0]  strb_q, strb_d;
   logic [STRB_WIDTH-1:0]  keep_q, keep_d;
   logic                   last_q, last_d;
   logic [ID_WIDTH-1:0]    id_q, id_d;
   logic [DEST_WIDTH-1:0]  dest_q, dest_d;
   logic [USER_WIDTH-1:0]  user_q, user_d;

   // Rotating search: first valid port at or after ptr_q, wrapping at N_PORT.
   always_comb begin : rr_search
      int unsigned idx;
      logic [PTR_WIDTH-1:0] idx_p;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      idx_p = '0;
      for (int unsigned k = 0; k < N_PORT; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N_PORT) begin
            idx = idx - N_PORT;
         end
         idx_p = PTR_WIDTH'(idx);
         if (!found && s_t_valid[idx_p]) begin
            found = 1'b1;
            sel   = idx_p;
         end
      end
   end

   always_comb begin : ctrl
      can_load  = !valid_q || m_t_ready;
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      s_t_ready = '0;

      if (state_q == StLocked) begin
         cur       = gnt_q;
         cur_valid = s_t_valid[gnt_q];
      end else begin
         cur       = sel;
         cur_valid = found;
      end

      if (aresetn && can_load && ((state_q == StLocked) || found)) begin
         s_t_ready[cur] = 1'b1;
      end
      accept   = aresetn && can_load && cur_valid;
      cur_next = (cur == PTR_WIDTH'(N_PORT - 1)) ? '0 : cur + 1'b1;

      if (accept) begin
         if (s_t_last[cur]) begin
            state_d = StIdle;
            ptr_d   = cur_next;
         end else begin
            state_d = StLocked;
            gnt_d   = cur;
         end
      end
   end

   always_comb begin : field_mux
      data_d = s_t_data[cur*DATA_WIDTH +: DATA_WIDTH];
      strb_d = s_t_strb[cur*STRB_WIDTH +: STRB_WIDTH];
      keep_d = s_t_keep[cur*STRB_WIDTH +: STRB_WIDTH];
      last_d = s_t_last[cur];
      dest_d = s_t_dest[cur*DEST_WIDTH +: DEST_WIDTH];
      user_d = s_t_user[cur*USER_WIDTH +: USER_WIDTH];
      if (TAG_SRC != 0) begin
         id_d = ID_WIDTH'(cur);
      end else begin
         id_d = s_t_id[cur*ID_WIDTH +: ID_WIDTH];
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         strb_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         id_q    <= '0;
         dest_q  <= '0;
         user_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         if (accept) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            strb_q  <= strb_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
         end else if (m_t_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign m_t_valid = valid_q;
   assign m_t_data  = data_q;
   assign m_t_strb  = strb_q;
   assign m_t_keep  = keep_q;
   assign m_t_last  = last_q;
   assign m_t_id    = id_q;
   assign m_t_dest  = dest_q;
   assign m_t_user  = user_q;

endmodule

// File: tb/tb_nasti_stream_rr_arbiter.sv
// Directed bench for nasti_stream_rr_arbiter: reset, fairness, packet lock, backpressure,
// mid-packet source gap and reset-during-packet restart.
module tb_nasti_stream_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int IW = 3;
   localparam int SW = DW / 8;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [NP-1:0]     s_t_valid, s_t_ready, s_t_last;
   logic [NP*DW-1:0]  s_t_data;
   logic [NP*SW-1:0]  s_t_strb, s_t_keep;
   logic [NP*IW-1:0]  s_t_id;
   logic [NP-1:0]     s_t_dest, s_t_user;
   logic              m_t_valid, m_t_ready, m_t_last;
   logic [DW-1:0]     m_t_data;
   logic [SW-1:0]     m_t_strb, m_t_keep;
   logic [IW-1:0]     m_t_id;
   logic              m_t_dest, m_t_user;

   nasti_stream_rr_arbiter #(
      .N_PORT(NP), .ID_WIDTH(IW), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(DW), .TAG_SRC(1)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_data(s_t_data),
      .s_t_strb(s_t_strb), .s_t_keep(s_t_keep), .s_t_last(s_t_last), .s_t_id(s_t_id),
      .s_t_dest(s_t_dest), .s_t_user(s_t_user),
      .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_data(m_t_data),
      .m_t_strb(m_t_strb), .m_t_keep(m_t_keep), .m_t_last(m_t_last), .m_t_id(m_t_id),
      .m_t_dest(m_t_dest), .m_t_user(m_t_user)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Per-port source beat stores
   logic [63:0] pd [NP][64];
   logic        pl [NP][64];
   int          wr [NP];
   int          rd [NP];
   bit          hold [NP];

   // Output beat log
   logic [63:0] lg_d [$];
   logic [7:0]  lg_s [$];
   logic [2:0]  lg_i [$];
   logic        lg_l [$];
   int          lg_c [$];

   logic [63:0] sb [$];
   bit          stall_chk;
   logic [3:0]  rdy_pat;
   int          rdy_idx;
   int          cyc;

   task automatic push_beat(input int p, input logic [63:0] d, input logic last);
      pd[p][wr[p]] = d;
      pl[p][wr[p]] = last;
      wr[p]++;
   endtask

   task automatic push_pkt(input int p, input logic [63:0] base, input int len);
      for (int n = 0; n < len; n++) push_beat(p, base + 64'(n), n == len - 1);
   endtask

   task automatic flush();
      for (int p = 0; p < NP; p++) begin
         wr[p] = 0; rd[p] = 0; hold[p] = 0;
      end
   endtask

   task automatic clear_log();
      lg_d.delete(); lg_s.delete(); lg_i.delete(); lg_l.delete(); lg_c.delete();
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         logic [63:0] d;
         logic        have;
         have = rd[p] < wr[p];
         d    = have ? pd[p][rd[p]] : 64'h0;
         s_t_valid[p]          = have && !hold[p];
         s_t_last[p]           = have ? pl[p][rd[p]] : 1'b0;
         s_t_data[p*DW +: DW]  = d;
         s_t_strb[p*SW +: SW]  = d[7:0];
         s_t_keep[p*SW +: SW]  = ~d[7:0];
         s_t_id[p*IW +: IW]    = 3'(7 - p);
         s_t_dest[p]           = p[0];
         s_t_user[p]           = ~p[0];
      end
   endtask

   // One clock: drive at negedge, sample handshakes, pop accepted source beats afterwards.
   task automatic do_cycle();
      logic [NP-1:0] hs;
      drive();
      m_t_ready = rdy_pat[rdy_idx % 4];
      rdy_idx++;
      #1;
      hs = s_t_valid & s_t_ready;
      if (stall_chk && m_t_valid) begin
         if (lg_d.size() < sb.size()) check("t4_hold_data", m_t_data, sb[lg_d.size()]);
         else check("t4_extra_beat", 64'(lg_d.size()), 64'(sb.size()));
      end
      if (m_t_valid && m_t_ready) begin
         lg_d.push_back(m_t_data);
         lg_s.push_back(m_t_strb);
         lg_i.push_back(m_t_id);
         lg_l.push_back(m_t_last);
         lg_c.push_back(cyc);
      end
      @(posedge aclk);
      @(negedge aclk);
      cyc++;
      for (int p = 0; p < NP; p++) if (hs[p]) rd[p]++;
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int k = 0;
      while (lg_d.size() < n && k < budget) begin
         do_cycle();
         k++;
      end
      check({tag, "_count"}, 64'(lg_d.size()), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn   = 1'b0;
      m_t_ready = 1'b1;
      s_t_valid = '0; s_t_last = '0; s_t_data = '0; s_t_strb = '0; s_t_keep = '0;
      s_t_id = '0; s_t_dest = '0; s_t_user = '0;
      rdy_pat = 4'hF; rdy_idx = 0; stall_chk = 0; cyc = 0;
      flush();
      for (int n = 0; n < 3; n++)
         for (int p = 0; p < NP; p++) push_beat(p, 64'h20000 + 64'(p * 256 + n), 1'b1);

      // T1: reset held with all sources valid
      @(negedge aclk);
      do_cycle();
      repeat (3) begin
         do_cycle();
         check("t1_s_ready", 64'(s_t_ready), 64'h0);
         check("t1_m_valid", 64'(m_t_valid), 64'h0);
         check("t1_m_data", m_t_data, 64'h0);
      end

      // T2: single-beat packets from all ports, id 0,1,2,3 repeating, one beat per cycle
      aresetn = 1'b1;
      clear_log();
      run_until(12, 40, "t2");
      for (int i = 0; i < 12 && i < lg_d.size(); i++) begin
         check("t2_id", 64'(lg_i[i]), 64'(i % 4));
         check("t2_data", lg_d[i], 64'h20000 + 64'((i % 4) * 256 + i / 4));
         check("t2_cycle", 64'(lg_c[i] - lg_c[0]), 64'(i));
      end
      if (lg_s.size() > 5) check("t2_strb", 64'(lg_s[5]), 64'h1);

      // T3: port 2 five-beat packet locks out port 0
      clear_log();
      push_pkt(2, 64'h30200, 5);
      do_cycle();
      push_beat(0, 64'h30000, 1'b1);
      push_beat(0, 64'h30001, 1'b1);
      run_until(7, 30, "t3");
      for (int i = 0; i < 7 && i < lg_d.size(); i++) begin
         check("t3_cycle", 64'(lg_c[i] - lg_c[0]), 64'(i));
         if (i < 5) begin
            check("t3_id", 64'(lg_i[i]), 64'h2);
            check("t3_data", lg_d[i], 64'h30200 + 64'(i));
            check("t3_last", 64'(lg_l[i]), 64'(i == 4));
         end else begin
            check("t3_id", 64'(lg_i[i]), 64'h0);
            check("t3_data", lg_d[i], 64'h30000 + 64'(i - 5));
         end
      end

      // T4: output ready pattern 1,0,0,1 during a port-1 packet
      clear_log();
      sb.delete();
      for (int i = 0; i < 4; i++) sb.push_back(64'h40100 + 64'(i));
      rdy_pat = 4'b1001; rdy_idx = 0; stall_chk = 1;
      push_pkt(1, 64'h40100, 4);
      run_until(4, 40, "t4");
      repeat (4) do_cycle();
      stall_chk = 0;
      rdy_pat = 4'hF;
      check("t4_total", 64'(lg_d.size()), 64'h4);
      for (int i = 0; i < 4 && i < lg_d.size(); i++) begin
         check("t4_data", lg_d[i], 64'h40100 + 64'(i));
         check("t4_id", 64'(lg_i[i]), 64'h1);
         check("t4_last", 64'(lg_l[i]), 64'(i == 3));
      end

      // T5: port 1 stalls mid-packet while port 3 waits
      clear_log();
      push_pkt(1, 64'h50100, 4);
      do_cycle();
      push_beat(3, 64'h50300, 1'b1);
      do_cycle();
      hold[1] = 1;
      repeat (3) begin
         do_cycle();
         check("t5_p3_ready", 64'(s_t_ready[3]), 64'h0);
      end
      hold[1] = 0;
      run_until(5, 30, "t5");
      for (int i = 0; i < 5 && i < lg_d.size(); i++) begin
         if (i < 4) begin
            check("t5_id", 64'(lg_i[i]), 64'h1);
            check("t5_data", lg_d[i], 64'h50100 + 64'(i));
            check("t5_last", 64'(lg_l[i]), 64'(i == 3));
         end else begin
            check("t5_id", 64'(lg_i[i]), 64'h3);
            check("t5_data", lg_d[i], 64'h50300);
         end
      end

      // T6: reset mid-packet (port 2 locked, ptr at 2), then port 0 wins first
      clear_log();
      push_beat(1, 64'h60100, 1'b1);
      do_cycle();
      push_pkt(2, 64'h60200, 3);
      do_cycle();
      do_cycle();
      aresetn = 1'b0;
      repeat (2) begin
         do_cycle();
         check("t6_s_ready", 64'(s_t_ready), 64'h0);
         check("t6_m_valid", 64'(m_t_valid), 64'h0);
         check("t6_m_data", m_t_data, 64'h0);
         check("t6_m_id", 64'(m_t_id), 64'h0);
      end
      flush();
      clear_log();
      aresetn = 1'b1;
      push_beat(3, 64'h60300, 1'b1);
      push_beat(2, 64'h60210, 1'b1);
      push_beat(0, 64'h60000, 1'b1);
      run_until(3, 20, "t6");
      if (lg_d.size() == 3) begin
         check("t6_id0", 64'(lg_i[0]), 64'h0);
         check("t6_data0", lg_d[0], 64'h60000);
         check("t6_id1", 64'(lg_i[1]), 64'h2);
         check("t6_data1", lg_d[1], 64'h60210);
         check("t6_id2", 64'(lg_i[2]), 64'h3);
         check("t6_data2", lg_d[2], 64'h60300);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
